// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// UART_TX_PARITY_EN adds CTRL[2]=PODD and a PARITY state to the frame.
package uart_tx_dev_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIV    = 2'd1;
  localparam logic [1:0] ADDR_TXDATA = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IM = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned CTRL_PODD = 2;
  localparam int unsigned CTRL_W    = 3;
`else
  localparam int unsigned CTRL_W    = 2;
`endif

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_OVF   = 3;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } tx_state_e;

  function automatic logic [15:0] div_clamp(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO; a push into a full FIFO is accepted only when a pop occurs in the same cycle.
// Behaviour is identical with or without UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rp_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped UART transmitter: register file, TX FIFO and 8N1 bit-serial FSM with idle irq.
// UART_TX_PARITY_EN enables CTRL[2]=PODD and a parity bit between DATA and STOP.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [1:0]  addr,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        txd
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [CTRL_W-1:0] ctrl_q;
  logic [15:0]       divisor_q;
  logic              ovf_q, irq_q;

  tx_state_e   state_q;
  logic [15:0] cnt_q, div_q, div_eff;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        txd_q;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          en, im, busy, bit_done, ovf_set;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[31:16];

  assign en        = ctrl_q[CTRL_EN];
  assign im        = ctrl_q[CTRL_IM];
  assign busy      = (state_q != S_IDLE);
  assign bit_done  = (cnt_q == '0);
  assign div_eff   = div_clamp(divisor_q);
  assign fifo_push = we && (addr == ADDR_TXDATA);
  assign fifo_pop  = en && !fifo_empty &&
                     ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));
  assign ovf_set   = fifo_push && fifo_full && !fifo_pop;
  assign irq       = irq_q;
  assign txd       = txd_q;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= '0;
      divisor_q <= DIV_RESET;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (we && (addr == ADDR_CTRL)) ctrl_q    <= wdata[CTRL_W-1:0];
      if (we && (addr == ADDR_DIV))  divisor_q <= wdata[15:0];
      if (we && (addr == ADDR_STATUS)) ovf_q <= 1'b0;
      else if (ovf_set)                ovf_q <= 1'b1;
      irq_q <= im && en && fifo_empty && !busy;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_MIN;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (fifo_pop) begin
      // Pop only fires in IDLE or on the last STOP cycle, so STOP chains straight into START.
      state_q <= S_START;
      txd_q   <= 1'b0;
      shift_q <= fifo_dout;
      div_q   <= div_eff;
      cnt_q   <= div_eff - 16'd1;
`ifdef UART_TX_PARITY_EN
      par_q   <= (^fifo_dout) ^ ctrl_q[CTRL_PODD];
`endif
    end else if (busy && !bit_done) begin
      cnt_q <= cnt_q - 16'd1;
    end else begin
      cnt_q <= div_q - 16'd1;
      case (state_q)
        S_START: begin
          state_q <= S_DATA;
          txd_q   <= shift_q[0];
          bit_q   <= '0;
        end
        S_DATA: begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_q <= S_PARITY;
            txd_q   <= par_q;
`else
            state_q <= S_STOP;
            txd_q   <= 1'b1;
`endif
          end else begin
            bit_q   <= bit_q + 3'd1;
            shift_q <= shift_q >> 1;
            txd_q   <= shift_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          state_q <= S_STOP;
          txd_q   <= 1'b1;
        end
`endif
        S_STOP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL:   rdata[CTRL_W-1:0] = ctrl_q;
      ADDR_DIV:    rdata[15:0]       = divisor_q;
      ADDR_STATUS: begin
        rdata[ST_BUSY]  = busy;
        rdata[ST_FULL]  = fifo_full;
        rdata[ST_EMPTY] = fifo_empty;
        rdata[ST_OVF]   = ovf_q;
        rdata[7:4]      = 4'(fifo_count);
      end
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev; covers the UART_TX_PARITY_EN build when the macro is defined.
module tb_uart_tx_dev;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wdata;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] rdata;
  logic        irq;
  logic        txd;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_dev #(.FIFO_DEPTH(4), .DIV_RESET(16'd434)) dut (
    .clk   (clk),
    .reset (reset),
    .wdata (wdata),
    .we    (we),
    .addr  (addr),
    .rdata (rdata),
    .irq   (irq),
    .txd   (txd)
  );

  // Expected txd waveform, one entry per clock: start, 8 data LSB first, optional parity, stop.
  function automatic void add_frame(input logic [7:0] b, input int unsigned div, input int par);
    for (int unsigned c = 0; c < div; c++) exp_q.push_back(1'b0);
    for (int unsigned i = 0; i < 8; i++)
      for (int unsigned c = 0; c < div; c++) exp_q.push_back(b[i]);
    if (par >= 0)
      for (int unsigned c = 0; c < div; c++) exp_q.push_back(par[0]);
    for (int unsigned c = 0; c < div; c++) exp_q.push_back(1'b1);
  endfunction

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    addr = 2'd3; #1;
    n_cmp++; if (rdata !== 32'h4) begin n_bad++; $display("FAIL reset_status: got %h want 00000004", rdata); end
    addr = 2'd0; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h want 00000000", rdata); end
    addr = 2'd1; #1;
    n_cmp++; if (rdata !== 32'd434) begin n_bad++; $display("FAIL reset_div: got %0d want 434", rdata); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame;
    wr(2'd1, 32'd4);
    wr(2'd0, 32'd1);
    exp_q.delete();
    add_frame(8'h55, 4, -1);
    wr(2'd2, 32'h55);
    addr = 2'd3;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      n_cmp++; if (txd !== exp_q[i]) begin n_bad++; $display("FAIL frame55 cyc %0d: got %b want %b", i, txd, exp_q[i]); end
      if (i == 0) begin
        n_cmp++; if (rdata !== 32'h5) begin n_bad++; $display("FAIL frame55_busy: got %h want 00000005", rdata); end
      end
    end
    @(negedge clk);
    n_cmp++; if (rdata !== 32'h4) begin n_bad++; $display("FAIL frame55_idle: got %h want 00000004", rdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL frame55_irq_masked: got %b want 0", irq); end
  endtask

  task automatic test_back_to_back;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'd3);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL b2b_irq_pre: got %b want 1", irq); end
    exp_q.delete();
    add_frame(8'hA5, 2, -1);
    add_frame(8'h0F, 2, -1);
    wr(2'd2, 32'hA5);
    wr(2'd2, 32'h0F);
    addr = 2'd3;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (txd !== exp_q[i]) begin n_bad++; $display("FAIL b2b cyc %0d: got %b want %b", i, txd, exp_q[i]); end
    end
    @(negedge clk);
    n_cmp++; if (rdata[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: got %b want 0", rdata[0]); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL b2b_irq_delay: got %b want 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL b2b_irq_rise: got %b want 1", irq); end
    wr(2'd0, 32'd0);
  endtask

  task automatic test_overflow;
    wr(2'd2, 32'h11);
    wr(2'd2, 32'h22);
    wr(2'd2, 32'h33);
    wr(2'd2, 32'h44);
    addr = 2'd3; #1;
    n_cmp++; if (rdata !== 32'h42) begin n_bad++; $display("FAIL ovf_full: got %h want 00000042", rdata); end
    wr(2'd2, 32'h99);
    addr = 2'd3; #1;
    n_cmp++; if (rdata !== 32'h4A) begin n_bad++; $display("FAIL ovf_set: got %h want 0000004a", rdata); end
    wr(2'd3, 32'h0);
    addr = 2'd3; #1;
    n_cmp++; if (rdata !== 32'h42) begin n_bad++; $display("FAIL ovf_clear: got %h want 00000042", rdata); end
    exp_q.delete();
    add_frame(8'h11, 2, -1);
    add_frame(8'h22, 2, -1);
    add_frame(8'h33, 2, -1);
    add_frame(8'h44, 2, -1);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'd1);
    addr = 2'd3;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      n_cmp++; if (txd !== exp_q[i]) begin n_bad++; $display("FAIL ovf_drain cyc %0d: got %b want %b", i, txd, exp_q[i]); end
    end
    @(negedge clk);
    n_cmp++; if (rdata !== 32'h4) begin n_bad++; $display("FAIL ovf_drained: got %h want 00000004", rdata); end
  endtask

  task automatic test_divisor;
    wr(2'd1, 32'd0);
    addr = 2'd1; #1;
    n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL div_zero_read: got %0d want 0", rdata); end
    exp_q.delete();
    add_frame(8'h3C, 2, -1);
    add_frame(8'hC3, 8, -1);
    wr(2'd2, 32'h3C);
    wr(2'd2, 32'hC3);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (i == 2) begin we = 1'b1; addr = 2'd1; wdata = 32'd8; end
      else we = 1'b0;
      n_cmp++; if (txd !== exp_q[i]) begin n_bad++; $display("FAIL div_change cyc %0d: got %b want %b", i, txd, exp_q[i]); end
    end
    @(negedge clk);
    addr = 2'd3; #1;
    n_cmp++; if (rdata !== 32'h4) begin n_bad++; $display("FAIL div_idle: got %h want 00000004", rdata); end
    addr = 2'd1; #1;
    n_cmp++; if (rdata !== 32'd8) begin n_bad++; $display("FAIL div_read: got %0d want 8", rdata); end
  endtask

  task automatic test_reset_mid;
    wr(2'd1, 32'd4);
    wr(2'd2, 32'hF0);
    wr(2'd2, 32'h00);
    repeat (9) @(negedge clk);
    n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL rstmid_pre: got %b want 0", txd); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL rstmid_txd: got %b want 1", txd); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rstmid_irq: got %b want 0", irq); end
    addr = 2'd3; #1;
    n_cmp++; if (rdata !== 32'h4) begin n_bad++; $display("FAIL rstmid_status: got %h want 00000004", rdata); end
    @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL rstmid_hold: got %b want 1", txd); end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle cyc %0d: got %b want 1", i, txd); end
    end
    n_cmp++; if (rdata !== 32'h4) begin n_bad++; $display("FAIL rstmid_after: got %h want 00000004", rdata); end
    addr = 2'd1; #1;
    n_cmp++; if (rdata !== 32'd434) begin n_bad++; $display("FAIL rstmid_div: got %0d want 434", rdata); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'd5);
    addr = 2'd0; #1;
    n_cmp++; if (rdata !== 32'd5) begin n_bad++; $display("FAIL par_ctrl: got %h want 00000005", rdata); end
    exp_q.delete();
    add_frame(8'h03, 2, 1);
    wr(2'd2, 32'h03);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      n_cmp++; if (txd !== exp_q[i]) begin n_bad++; $display("FAIL par_odd cyc %0d: got %b want %b", i, txd, exp_q[i]); end
    end
    @(negedge clk);
    wr(2'd0, 32'd1);
    exp_q.delete();
    add_frame(8'h03, 2, 0);
    wr(2'd2, 32'h03);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      n_cmp++; if (txd !== exp_q[i]) begin n_bad++; $display("FAIL par_even cyc %0d: got %b want %b", i, txd, exp_q[i]); end
    end
  endtask
`else
  task automatic test_ctrl_mask;
    wr(2'd0, 32'd5);
    addr = 2'd0; #1;
    n_cmp++; if (rdata !== 32'd1) begin n_bad++; $display("FAIL ctrl_mask: got %h want 00000001", rdata); end
    wr(2'd0, 32'd0);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_overflow();
    test_divisor();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`else
    test_ctrl_mask();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
